// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//
// Two-channel push-button/switch conditioner. It sits in front of the
// logic-gate block. Each channel has these stages:
//   raw pin -> 2-FF synchroniser -> polarity fix -> saturating debounce counter
//           -> stable-level register -> registered rise/fall strobes
//
// A new synchronised level is accepted once it has been seen on N consecutive
// clocks, where N = CLK_HZ/1000*DEBOUNCE_MS and N is at least 1. A steady raw
// change reaches a/b exactly 2+N rising edges after the first edge that
// samples it. Every output is registered, so no combinational path runs from
// a raw pin to an output.
//
// Optional build macro: DEBOUNCE_TOGGLE_EN
//   When it is defined, a/b act as toggle latches. Each debounced press inverts
//   the output and releases are ignored. The rise/fall strobes still report
//   the physical press and release of the button.
//
// Ports:
//   clk        in   system clock, rising-edge logic
//   rst_n      in   synchronous active-low reset
//   btn_a_raw  in   asynchronous raw pin, channel A
//   btn_b_raw  in   asynchronous raw pin, channel B
//   a, b       out  debounced logical level (1 = pressed) or toggle state
//   a_rise     out  one-cycle strobe, debounced A press
//   a_fall     out  one-cycle strobe, debounced A release
//   b_rise     out  one-cycle strobe, debounced B press
//   b_fall     out  one-cycle strobe, debounced B release
// -----------------------------------------------------------------------------
module input_debounce #(
    parameter int CLK_HZ      = 27000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam int N_CALC = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int N      = (N_CALC < 1) ? 1 : N_CALC;
    localparam int CW     = $clog2(N + 1);

    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    // Raw pin level that means "not pressed".
    localparam logic          INACTIVE = (ACTIVE_LOW != 0);

    logic [1:0] raw;
    logic [1:0] level_v;
    logic [1:0] rise_v;
    logic [1:0] fall_v;

    assign raw = {btn_b_raw, btn_a_raw};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          s;
        logic          stable;
        logic          accept;
        logic          rise;
        logic          fall;
        logic          level;
        logic [CW-1:0] cnt;

        // Logical sample: 1 means pressed, whatever the pin polarity.
        assign s      = sync2 ^ INACTIVE;
        // Seen for N-1 earlier cycles and still different now: accept on this edge.
        assign accept = (s != stable) && (cnt == LAST);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1  <= INACTIVE;
                sync2  <= INACTIVE;
                stable <= 1'b0;
                cnt    <= '0;
                rise   <= 1'b0;
                fall   <= 1'b0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (s == stable) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // Strobes are registered next to stable, so they line up with the level change.
                rise <= accept & s;
                fall <= accept & ~s;
            end
        end

`ifdef DEBOUNCE_TOGGLE_EN
        logic toggle;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                toggle <= 1'b0;
            end else if (accept && s) begin
                toggle <= ~toggle;
            end
        end

        assign level = toggle;
`else
        assign level = stable;
`endif

        assign level_v[i] = level;
        assign rise_v[i]  = rise;
        assign fall_v[i]  = fall;
    end

    assign a      = level_v[0];
    assign b      = level_v[1];
    assign a_rise = rise_v[0];
    assign a_fall = fall_v[0];
    assign b_rise = rise_v[1];
    assign b_fall = fall_v[1];

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Two-channel input conditioner that sits directly upstream of the logic-gate block.
- Takes raw board push-buttons/switches and produces clean, glitch-free level signals `a` and `b` to drive the gate inputs.
- Also produces single-cycle rise/fall strobes for downstream counters and LEDs.
- Per channel: 2-FF synchroniser, then saturating debounce counter, then stable-level register and edge detector.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- DEBOUNCE_MS, 10, time a synchronised input must hold a new level before it is accepted.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (inverted before the synchroniser output is used); 0 = raw pin reads 1 when pressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- btn_a_raw  input  1  asynchronous raw pin, channel A.
- btn_b_raw  input  1  asynchronous raw pin, channel B.
- a  output  1  debounced logical level, channel A (1 = pressed); feeds gate input a.
- b  output  1  debounced logical level, channel B; feeds gate input b.
- a_rise  output  1  one-cycle strobe when `a` goes 0->1.
- a_fall  output  1  one-cycle strobe when `a` goes 1->0.
- b_rise  output  1  one-cycle strobe when `b` goes 0->1.
- b_fall  output  1  one-cycle strobe when `b` goes 1->0.

Behaviour:
- Debounce count:
  - N = CLK_HZ/1000*DEBOUNCE_MS, computed as a localparam.
  - If N < 1, N = 1.
  - Counter width is clog2(N+1).
- Synchroniser:
  - Two flops per channel.
  - Both reset to the raw level meaning "not pressed" (1 if ACTIVE_LOW, else 0).
  - Logical sample s = sync2 XOR ACTIVE_LOW.
- Per-channel debounce, each clock:
  - s == stable: counter clears to 0.
  - s != stable and counter < N-1: counter increments.
  - s != stable and counter == N-1: stable <= s, counter clears to 0.
- Latency:
  - Raw change held steady appears on a/b exactly 2+N rising edges after the first edge that samples it.
  - Rise/fall strobes assert in the same cycle a/b changes and last exactly one cycle.
- Glitch rejection:
  - Any excursion of s lasting fewer than N consecutive cycles leaves a/b unchanged and produces no strobe.
  - Counter restarts from 0 when s returns to the stable level.
- Channels are fully independent.
  - Simultaneous transitions on A and B resolve on the same cycle if the raw edges coincide.
- Counter never wraps; the accept comparison is equality to N-1.
- Reset values:
  - a, b = 0; all strobes = 0; counters = 0; sync flops = inactive level.
- Reset mid-operation:
  - rst_n low on any edge forces the reset state regardless of counter progress; a partially counted transition is discarded.
  - After rst_n rises, a button still held must re-qualify through the full 2+N cycles.
- No combinational path from raw inputs to any output; all outputs are registered.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined:
  - a and b become toggle latches: each debounced press (internal rise) inverts the output; releases have no effect on a/b.
  - a_rise/a_fall/b_rise/b_fall still report debounced press/release of the physical button, not the toggled output.
  - Toggle latches reset to 0.
- Not defined:
  - a/b follow the debounced button level directly as described in Behaviour.

Test Plan:
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=4 (N=4), ACTIVE_LOW=1.
1. Reset: hold rst_n=0 for 3 cycles with btn_a_raw=0 -> a=0, b=0, all strobes 0; release reset, keep btn_a_raw=0 -> a rises exactly 6 edges later with a_rise=1 for 1 cycle.
2. Glitch: drive btn_a_raw 1->0 for 3 cycles, then back to 1 -> a stays 0, a_rise never asserts.
3. Release: after a=1, drive btn_a_raw=1 steadily -> a falls 6 edges later, a_fall pulses once, a_rise stays 0.
4. Simultaneous: drive btn_a_raw and btn_b_raw low on the same edge -> a and b rise on the same cycle; a_rise and b_rise pulse together.
5. Mid-operation reset: drive btn_b_raw=0, assert rst_n=0 after 4 cycles for 1 cycle, keep button held -> b rises 6 edges after rst_n returns high, not earlier.
6. DEBOUNCE_TOGGLE_EN defined: two full press/release cycles on A -> a goes 0->1 on the first press, 1->0 on the second press, unchanged on releases; a_rise pulses twice, a_fall pulses twice.
